cordic_input_stage: RTL

//  Front end between the chip input pins and the CORDIC core.
//  - Synchronizes the 10-bit operand pins and the mode pin.
//  - Waits for the pin value to settle, then converts it to the core's
//    16-bit signed fixed-point angle format.
//  - Issues exactly one operation per distinct stable pin value, using a

---
 rtl/cordic_input_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cordic_input_stage.sv
// cordic_input_stage: pin synchronizer, settle filter and one-shot operand
// issue (valid/ready handshake) in front of the CORDIC core. The core's
// done pulse gates the next issue.
module cordic_input_stage #(
  parameter int IN_W          = 10,
  parameter int OP_W          = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IN_W-1:0] pin_val,
  input  logic            pin_mode,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [OP_W-1:0] op_angle,
  output logic            op_mode,
  input  logic            core_done,
  output logic            busy
);

  // Synchronized word is {mode, value}: a mode-only change is a new value.
  localparam int SW    = IN_W + 1;
  localparam int PAD_W = OP_W - IN_W;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  logic [SW-1:0]    w_pins;
  logic [SW-1:0]    w_sync1;
  logic [SW-1:0]    w_sync2;
  logic [CNT_W-1:0] r_stab_cnt;
  logic [SW-1:0]    r_last_issued;
  logic             r_first;
  logic [OP_W-1:0]  r_op_angle;
  logic             r_op_mode;
  state_t           r_state;
  state_t           w_state_next;
  logic             w_stable;
  logic             w_new_value;
  logic             w_load;
  logic             w_accept;
  logic             w_op_valid;
  logic             w_busy;
  logic [OP_W-1:0]  w_angle;

  assign w_pins = {pin_mode, pin_val};

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_sync
      logic r_meta;
      logic r_stable;
      // Two-flop synchronizer for one pin bit.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_meta   <= 1'b0;
          r_stable <= 1'b0;
        end else begin
          r_meta   <= w_pins[gi];
          r_stable <= r_meta;
        end
      end
      assign w_sync1[gi] = r_meta;
      assign w_sync2[gi] = r_stable;
    end
  endgenerate

  // Settle counter: restarts whenever the two sync stages disagree,
  // saturates once the value has been steady long enough. Runs in all states.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stab_cnt <= '0;
    end else if (w_sync1 != w_sync2) begin
      r_stab_cnt <= '0;
    end else if (r_stab_cnt != CNT_MAX) begin
      r_stab_cnt <= r_stab_cnt + 1'b1;
    end
  end

  assign w_stable    = (r_stab_cnt == CNT_MAX);
  assign w_new_value = r_first || (w_sync2 != r_last_issued);
  // Appending zeros below the two's complement value keeps its sign.
  assign w_angle     = {w_sync2[IN_W-1:0], {PAD_W{1'b0}}};

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and Moore outputs; done/ready outside their states are ignored.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_accept     = 1'b0;
    w_op_valid   = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_stable && w_new_value) begin
          w_state_next = ST_ISSUE;
          w_load       = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_op_valid = 1'b1;
        w_busy     = 1'b1;
        if (op_ready) begin
          w_state_next = ST_WAIT;
          w_accept     = 1'b1;
        end
      end
      ST_WAIT: begin
        w_busy = 1'b1;
        if (core_done) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Operand capture on issue; held through ISSUE regardless of pin activity.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op_angle <= '0;
      r_op_mode  <= 1'b0;
    end else if (w_load) begin
      r_op_angle <= w_angle;
      r_op_mode  <= w_sync2[IN_W];
    end
  end

  // Remember what the core accepted so the same stable value is not re-issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_issued <= '0;
      r_first       <= 1'b1;
    end else if (w_accept) begin
      r_last_issued <= {r_op_mode, r_op_angle[OP_W-1 -: IN_W]};
      r_first       <= 1'b0;
    end
  end

  assign op_valid = w_op_valid;
  assign busy     = w_busy;
  assign op_angle = r_op_angle;
  assign op_mode  = r_op_mode;

endmodule
